pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_pkg.sv | 30 +++
 rtl/pipe_hazard_ctrl_if.sv | 54 +++++
 rtl/fwd_sel.sv | 62 ++++++
 rtl/pipe_hazard_ctrl.sv | 111 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared definitions for the pipeline hazard controller:
//                forwarding source codes, the "operand unused" Tuse code,
//                MDU busy-counter width and default MDU latencies.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Operand source selection for the decode stage
    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_E  = 2'd1,
        FWD_M  = 2'd2,
        FWD_W  = 2'd3
    } fwd_src_e;

    // Tuse value meaning "this operand is not read by the instruction"
    localparam logic [1:0] TUSE_NONE = 2'd3;

    // Default MDU busy lengths (cycles of md_busy after a start)
    localparam int MULT_CYC_DEFAULT = 5;
    localparam int DIV_CYC_DEFAULT  = 10;

    // Width of the MDU busy counter
    localparam int MDU_CNT_W = 4;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl_if
//  Description : Bundle between the pipeline datapath and the hazard
//                controller. The master side (pipeline) drives the stage
//                register/Tuse/Tnew information and MDU events; the slave
//                side (hazard controller) returns stall/flush/forwarding
//                selects and the MDU busy flag.
//  Ports       : D_rs_addr/D_rt_addr, D_rs_tuse/D_rt_tuse,
//                E_A3/M_A3/W_A3, E_regwe/M_regwe/W_regwe, E_tnew/M_tnew,
//                D_md_use, E_md_start, E_md_div            (master -> slave)
//                stall, E_flush, fwd_rs, fwd_rt, md_busy    (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_hazard_ctrl_if;

    logic [4:0] D_rs_addr;
    logic [4:0] D_rt_addr;
    logic [1:0] D_rs_tuse;
    logic [1:0] D_rt_tuse;
    logic [4:0] E_A3;
    logic [4:0] M_A3;
    logic [4:0] W_A3;
    logic       E_regwe;
    logic       M_regwe;
    logic       W_regwe;
    logic [1:0] E_tnew;
    logic [1:0] M_tnew;
    logic       D_md_use;
    logic       E_md_start;
    logic       E_md_div;

    logic       stall;
    logic       E_flush;
    logic [1:0] fwd_rs;
    logic [1:0] fwd_rt;
    logic       md_busy;

    modport master (
        output D_rs_addr, D_rt_addr, D_rs_tuse, D_rt_tuse,
        output E_A3, M_A3, W_A3, E_regwe, M_regwe, W_regwe,
        output E_tnew, M_tnew, D_md_use, E_md_start, E_md_div,
        input  stall, E_flush, fwd_rs, fwd_rt, md_busy
    );

    modport slave (
        input  D_rs_addr, D_rt_addr, D_rs_tuse, D_rt_tuse,
        input  E_A3, M_A3, W_A3, E_regwe, M_regwe, W_regwe,
        input  E_tnew, M_tnew, D_md_use, E_md_start, E_md_div,
        output stall, E_flush, fwd_rs, fwd_rt, md_busy
    );

endinterface : pipe_hazard_ctrl_if
`default_nettype wire

// File: rtl/fwd_sel.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_sel
//  Description : Per-operand hazard logic. Detects producer matches in the
//                E, M and W stages, raises a data stall when the producer
//                cannot deliver before the operand is needed, and picks the
//                youngest ready forwarding source (E > M > W > RF).
//  Ports       : addr_i, tuse_i            - decode operand and its Tuse
//                e_/m_/w_ a3_i, regwe_i    - stage destination and write enable
//                e_tnew_i, m_tnew_i        - stage result readiness
//                fwd_o                     - forwarding select
//                stall_o                   - data hazard stall for this operand
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_sel
    import pipe_pkg::*;
(
    input  wire logic [4:0] addr_i,
    input  wire logic [1:0] tuse_i,
    input  wire logic [4:0] e_a3_i,
    input  wire logic       e_regwe_i,
    input  wire logic [1:0] e_tnew_i,
    input  wire logic [4:0] m_a3_i,
    input  wire logic       m_regwe_i,
    input  wire logic [1:0] m_tnew_i,
    input  wire logic [4:0] w_a3_i,
    input  wire logic       w_regwe_i,
    output logic      [1:0] fwd_o,
    output logic            stall_o
);

    logic w_nonzero;
    logic w_e_match;
    logic w_m_match;
    logic w_w_match;

    // $zero is hard-wired, so it can neither be a hazard nor a forward target
    assign w_nonzero = (addr_i != 5'd0);
    assign w_e_match = w_nonzero && (addr_i == e_a3_i) && e_regwe_i;
    assign w_m_match = w_nonzero && (addr_i == m_a3_i) && m_regwe_i;
    assign w_w_match = w_nonzero && (addr_i == w_a3_i) && w_regwe_i;

    // A not-yet-ready E producer shadows nothing: the chain falls through
    // to M/W, but the stall below holds D until E's value becomes usable.
    always_comb begin
        fwd_o = FWD_RF;
        if (w_e_match && (e_tnew_i == 2'd0)) begin
            fwd_o = FWD_E;
        end else if (w_m_match && (m_tnew_i == 2'd0)) begin
            fwd_o = FWD_M;
        end else if (w_w_match) begin
            fwd_o = FWD_W;
        end
    end

    // Tnew is at most 3, so an unused operand (Tuse = 3) never stalls
    assign stall_o = (tuse_i != TUSE_NONE) &&
                     ((w_e_match && (e_tnew_i > tuse_i)) ||
                      (w_m_match && (m_tnew_i > tuse_i)));

endmodule : fwd_sel
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Pipeline hazard controller. Combines the rs/rt data stalls
//                from two fwd_sel instances with an optional MDU busy
//                tracker into stall/E_flush, and reports forwarding selects.
//                Build option: define PIPE_HAZARD_MDU_EN to include the MDU
//                busy counter and MDU stall; otherwise md_busy is tied low
//                and the MDU inputs are ignored.
//  Ports       : clk   - rising-edge clock
//                reset - synchronous, active-high reset
//                hz    - pipe_hazard_ctrl_if.slave bundle
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int MULT_CYC = pipe_pkg::MULT_CYC_DEFAULT,
    parameter int DIV_CYC  = pipe_pkg::DIV_CYC_DEFAULT
) (
    input wire logic          clk,
    input wire logic          reset,
    pipe_hazard_ctrl_if.slave hz
);

    import pipe_pkg::*;

    logic [1:0] w_fwd_rs;
    logic [1:0] w_fwd_rt;
    logic       w_rs_stall;
    logic       w_rt_stall;
    logic       w_md_stall;
    logic       w_md_busy;
    logic       w_stall;

    fwd_sel u_fwd_rs (
        .addr_i    (hz.D_rs_addr),
        .tuse_i    (hz.D_rs_tuse),
        .e_a3_i    (hz.E_A3),
        .e_regwe_i (hz.E_regwe),
        .e_tnew_i  (hz.E_tnew),
        .m_a3_i    (hz.M_A3),
        .m_regwe_i (hz.M_regwe),
        .m_tnew_i  (hz.M_tnew),
        .w_a3_i    (hz.W_A3),
        .w_regwe_i (hz.W_regwe),
        .fwd_o     (w_fwd_rs),
        .stall_o   (w_rs_stall)
    );

    fwd_sel u_fwd_rt (
        .addr_i    (hz.D_rt_addr),
        .tuse_i    (hz.D_rt_tuse),
        .e_a3_i    (hz.E_A3),
        .e_regwe_i (hz.E_regwe),
        .e_tnew_i  (hz.E_tnew),
        .m_a3_i    (hz.M_A3),
        .m_regwe_i (hz.M_regwe),
        .m_tnew_i  (hz.M_tnew),
        .w_a3_i    (hz.W_A3),
        .w_regwe_i (hz.W_regwe),
        .fwd_o     (w_fwd_rt),
        .stall_o   (w_rt_stall)
    );

`ifdef PIPE_HAZARD_MDU_EN
    localparam logic [MDU_CNT_W-1:0] MULT_LOAD = MDU_CNT_W'(MULT_CYC);
    localparam logic [MDU_CNT_W-1:0] DIV_LOAD  = MDU_CNT_W'(DIV_CYC);

    logic [MDU_CNT_W-1:0] cnt_q;
    logic [MDU_CNT_W-1:0] cnt_d;

    // A start is accepted when idle, or on the last busy cycle (count = 1)
    // so back-to-back operations leave no idle gap. Any other start while
    // busy is dropped and does not extend the current count.
    always_comb begin
        cnt_d = cnt_q;
        if (hz.E_md_start && (cnt_q <= MDU_CNT_W'(1))) begin
            cnt_d = hz.E_md_div ? DIV_LOAD : MULT_LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - MDU_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign w_md_busy  = (cnt_q != '0);
    // An MDU access in D must also wait for a start that is only now in E
    assign w_md_stall = hz.D_md_use && (w_md_busy || hz.E_md_start);
`else
    logic w_md_unused;

    assign w_md_unused = ^{clk, hz.D_md_use, hz.E_md_start, hz.E_md_div};
    assign w_md_busy   = 1'b0;
    assign w_md_stall  = 1'b0;
`endif

    // Outputs are forced quiet while reset is held
    assign w_stall    = w_rs_stall || w_rt_stall || w_md_stall;
    assign hz.stall   = !reset && w_stall;
    assign hz.E_flush = !reset && w_stall;
    assign hz.fwd_rs  = reset ? FWD_RF : w_fwd_rs;
    assign hz.fwd_rt  = reset ? FWD_RF : w_fwd_rt;
    assign hz.md_busy = !reset && w_md_busy;

endmodule : pipe_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_hazard_ctrl
//  Description : Self-checking bench for pipe_hazard_ctrl: reset check,
//                directed vector table for forwarding/stall, hand-written
//                MDU sequences, and randomized traffic against a
//                cycle-numbered reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    import pipe_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;
`ifdef PIPE_HAZARD_MDU_EN
    localparam bit MDU_EN = 1'b1;
`else
    localparam bit MDU_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if hz ();

    pipe_hazard_ctrl #(
        .MULT_CYC (MULT_N),
        .DIV_CYC  (DIV_N)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    // MDU reference: md_busy is high in every cycle c with c < busy_until
    int busy_until = 0;

    typedef struct {
        logic [4:0] rs, rt;
        logic [1:0] rs_tuse, rt_tuse;
        logic [4:0] ea3, ma3, wa3;
        logic       ewe, mwe, wwe;
        logic [1:0] etn, mtn;
        logic       exp_stall;
        logic [1:0] exp_rs, exp_rt;
    } vec_t;

    vec_t vecs[10];

    function automatic vec_t mkv(int rs, int rt, int rsu, int rtu,
                                 int ea, int ma, int wa,
                                 int ew, int mw, int ww, int etn, int mtn,
                                 int st, int frs, int frt);
        vec_t v;
        v.rs = 5'(rs);  v.rt = 5'(rt);
        v.rs_tuse = 2'(rsu); v.rt_tuse = 2'(rtu);
        v.ea3 = 5'(ea); v.ma3 = 5'(ma); v.wa3 = 5'(wa);
        v.ewe = 1'(ew); v.mwe = 1'(mw); v.wwe = 1'(ww);
        v.etn = 2'(etn); v.mtn = 2'(mtn);
        v.exp_stall = 1'(st);
        v.exp_rs = 2'(frs); v.exp_rt = 2'(frt);
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- reference model ----------------
    function automatic int ref_src(input logic [4:0] a);
        if (a == 5'd0) return 0;
        if (hz.E_regwe && hz.E_A3 == a && hz.E_tnew == 2'd0) return 1;
        if (hz.M_regwe && hz.M_A3 == a && hz.M_tnew == 2'd0) return 2;
        if (hz.W_regwe && hz.W_A3 == a) return 3;
        return 0;
    endfunction

    function automatic bit ref_wait(input logic [4:0] a, input logic [1:0] tuse);
        if (a == 5'd0) return 1'b0;
        if (hz.E_regwe && hz.E_A3 == a && int'(hz.E_tnew) > int'(tuse)) return 1'b1;
        if (hz.M_regwe && hz.M_A3 == a && int'(hz.M_tnew) > int'(tuse)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit ref_busy();
        return !reset && MDU_EN && (cyc < busy_until);
    endfunction

    function automatic bit ref_stall();
        bit md;
        md = MDU_EN && hz.D_md_use && ((cyc < busy_until) || hz.E_md_start);
        return !reset && (ref_wait(hz.D_rs_addr, hz.D_rs_tuse) ||
                          ref_wait(hz.D_rt_addr, hz.D_rt_tuse) || md);
    endfunction

    task automatic check_all(input string tag);
        bit s;
        s = ref_stall();
        chk({tag, ".stall"},   int'(hz.stall),   int'(s));
        chk({tag, ".E_flush"}, int'(hz.E_flush), int'(s));
        chk({tag, ".fwd_rs"},  int'(hz.fwd_rs),  reset ? 0 : ref_src(hz.D_rs_addr));
        chk({tag, ".fwd_rt"},  int'(hz.fwd_rt),  reset ? 0 : ref_src(hz.D_rt_addr));
        chk({tag, ".md_busy"}, int'(hz.md_busy), int'(ref_busy()));
    endtask

    // Advance one clock; the model consumes the inputs held across the edge
    task automatic step();
        @(posedge clk);
        if (reset) begin
            busy_until = 0;
        end else if (MDU_EN && hz.E_md_start && (cyc + 1 >= busy_until)) begin
            busy_until = cyc + 1 + (hz.E_md_div ? DIV_N : MULT_N);
        end
        cyc++;
        #1;
    endtask

    task automatic clear_inputs();
        hz.D_rs_addr = '0; hz.D_rt_addr = '0;
        hz.D_rs_tuse = TUSE_NONE; hz.D_rt_tuse = TUSE_NONE;
        hz.E_A3 = '0; hz.M_A3 = '0; hz.W_A3 = '0;
        hz.E_regwe = 1'b0; hz.M_regwe = 1'b0; hz.W_regwe = 1'b0;
        hz.E_tnew = '0; hz.M_tnew = '0;
        hz.D_md_use = 1'b0; hz.E_md_start = 1'b0; hz.E_md_div = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v);
        hz.D_rs_addr = v.rs; hz.D_rt_addr = v.rt;
        hz.D_rs_tuse = v.rs_tuse; hz.D_rt_tuse = v.rt_tuse;
        hz.E_A3 = v.ea3; hz.M_A3 = v.ma3; hz.W_A3 = v.wa3;
        hz.E_regwe = v.ewe; hz.M_regwe = v.mwe; hz.W_regwe = v.wwe;
        hz.E_tnew = v.etn; hz.M_tnew = v.mtn;
    endtask

    // MDU sequence: per cycle k, start/reset come from masks and md_busy
    // must equal exp_m[k] (only in builds with the MDU present)
    task automatic mdu_seq(input string name, input logic [15:0] start_m,
                           input logic div, input logic [15:0] rst_m,
                           input logic [15:0] exp_m, input int ncyc);
        bit eb, es;
        clear_inputs();
        hz.D_md_use = 1'b1;
        hz.E_md_div = div;
        for (int k = 0; k < ncyc; k++) begin
            hz.E_md_start = start_m[k];
            reset         = rst_m[k];
            #1;
            eb = MDU_EN && exp_m[k];
            es = !reset && MDU_EN && (exp_m[k] || start_m[k]);
            chk($sformatf("%s.md_busy[%0d]", name, k), int'(hz.md_busy), int'(eb));
            chk($sformatf("%s.stall[%0d]", name, k),   int'(hz.stall),   int'(es));
            step();
        end
        reset = 1'b0;
        clear_inputs();
    endtask

    initial begin
        // ---------------- reset ----------------
        clear_inputs();
        reset = 1'b1;
        apply_vec(mkv(8, 9, 0, 1, 9, 9, 9, 1, 1, 1, 0, 0, 0, 0, 0));
        hz.E_md_start = 1'b1; hz.D_md_use = 1'b1;
        #1;
        chk("rst.stall",   int'(hz.stall),   0);
        chk("rst.E_flush", int'(hz.E_flush), 0);
        chk("rst.fwd_rs",  int'(hz.fwd_rs),  0);
        chk("rst.fwd_rt",  int'(hz.fwd_rt),  0);
        chk("rst.md_busy", int'(hz.md_busy), 0);
        step();
        step();
        reset = 1'b0;
        clear_inputs();
        #1;
        chk("post_rst.md_busy", int'(hz.md_busy), 0);

        // ---------------- directed vectors ----------------
        //               rs rt su tu ea ma wa ew mw ww et mt st frs frt
        vecs[0] = mkv(8, 0, 0, 3, 8, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0);
        vecs[1] = mkv(8, 0, 0, 3, 0, 8, 0, 0, 1, 0, 0, 0, 0, 2, 0);
        vecs[2] = mkv(0, 9, 3, 1, 9, 9, 9, 1, 1, 1, 0, 0, 0, 0, 1);
        vecs[3] = mkv(0, 9, 3, 1, 9, 9, 9, 0, 1, 1, 0, 0, 0, 0, 2);
        vecs[4] = mkv(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 2, 2, 0, 0, 0);
        vecs[5] = mkv(5, 0, 0, 3, 0, 0, 5, 0, 0, 1, 0, 0, 0, 3, 0);
        vecs[6] = mkv(0, 7, 3, 1, 0, 7, 0, 0, 1, 0, 0, 2, 1, 0, 0);
        vecs[7] = mkv(6, 0, 2, 3, 6, 0, 0, 1, 0, 0, 2, 0, 0, 0, 0);
        vecs[8] = mkv(6, 6, 3, 3, 6, 0, 0, 1, 0, 0, 3, 0, 0, 0, 0);
        vecs[9] = mkv(4, 4, 1, 0, 4, 4, 0, 1, 1, 0, 1, 0, 1, 2, 2);
        for (int i = 0; i < 10; i++) begin
            apply_vec(vecs[i]);
            #1;
            chk($sformatf("vec%0d.stall", i),   int'(hz.stall),   int'(vecs[i].exp_stall));
            chk($sformatf("vec%0d.E_flush", i), int'(hz.E_flush), int'(vecs[i].exp_stall));
            chk($sformatf("vec%0d.fwd_rs", i),  int'(hz.fwd_rs),  int'(vecs[i].exp_rs));
            chk($sformatf("vec%0d.fwd_rt", i),  int'(hz.fwd_rt),  int'(vecs[i].exp_rt));
            step();
        end
        clear_inputs();
        step();

        // ---------------- MDU sequences ----------------
        mdu_seq("div",       16'h0001, 1'b1, 16'h0000, 16'h07FE, 12);
        mdu_seq("mult_ign",  16'h0005, 1'b0, 16'h0000, 16'h003E, 8);
        mdu_seq("mult_b2b",  16'h0021, 1'b0, 16'h0000, 16'h07FE, 12);
        mdu_seq("div_rst",   16'h0001, 1'b1, 16'h0008, 16'h0006, 7);

        // ---------------- randomized traffic ----------------
        for (int i = 0; i < 400; i++) begin
            hz.D_rs_addr  = 5'($urandom_range(0, 3));
            hz.D_rt_addr  = 5'($urandom_range(0, 3));
            hz.D_rs_tuse  = 2'($urandom_range(0, 3));
            hz.D_rt_tuse  = 2'($urandom_range(0, 3));
            hz.E_A3       = 5'($urandom_range(0, 3));
            hz.M_A3       = 5'($urandom_range(0, 3));
            hz.W_A3       = 5'($urandom_range(0, 3));
            hz.E_regwe    = 1'($urandom_range(0, 1));
            hz.M_regwe    = 1'($urandom_range(0, 1));
            hz.W_regwe    = 1'($urandom_range(0, 1));
            hz.E_tnew     = 2'($urandom_range(0, 3));
            hz.M_tnew     = 2'($urandom_range(0, 3));
            hz.D_md_use   = 1'($urandom_range(0, 1));
            hz.E_md_start = ($urandom_range(0, 5) == 0);
            hz.E_md_div   = 1'($urandom_range(0, 1));
            reset         = ($urandom_range(0, 49) == 0);
            #1;
            check_all($sformatf("rnd%0d", i));
            step();
        end
        reset = 1'b0;
        clear_inputs();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_pipe_hazard_ctrl
`default_nettype wire
